// File: rtl/countdown_seg_scanner_if.sv
// Bus between the traffic controller and the seven-segment scanner:
// countdown load strobe and values, blanking level, and the display drive.
interface countdown_seg_scanner_if;
  logic       load;
  logic [4:0] count1;
  logic [4:0] count2;
  logic       blank;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame;

  modport master (
    output load, count1, count2, blank,
    input  seg, an, frame
  );

  modport slave (
    input  load, count1, count2, blank,
    output seg, an, frame
  );
endinterface

// File: rtl/countdown_seg_scanner.sv
// Scans two 0..31 countdowns onto a 4-digit seven-segment display with a
// dark cycle at every slot start. Define LZ_BLANK_EN to suppress leading-zero tens digits.
module countdown_seg_scanner #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  countdown_seg_scanner_if.slave  bus
);

  localparam logic [15:0] SLOT_LAST = 16'(SCAN_DIV - 1);

  logic [4:0]  pend1, pend2;
  logic [4:0]  shd1, shd2;
  logic [15:0] slot_cnt;
  logic [1:0]  idx;
  logic [6:0]  seg_q;
  logic [3:0]  an_q;
  logic        frame_q;

  logic        slot_wrap;
  logic        boundary;
  logic [15:0] nxt_slot;
  logic [1:0]  nxt_idx;
  logic [4:0]  nxt_shd1, nxt_shd2;
  logic [4:0]  cur_val;
  logic        is_tens;
  logic [1:0]  tens_v;
  logic [3:0]  ones_v;
  logic [3:0]  digit;
  logic        lz_dark;
  logic        lit;
  logic [6:0]  seg_d;
  logic [3:0]  an_d;

  function automatic logic [1:0] tens_of(input logic [4:0] v);
    if (v >= 5'd30)      return 2'd3;
    else if (v >= 5'd20) return 2'd2;
    else if (v >= 5'd10) return 2'd1;
    else                 return 2'd0;
  endfunction

  // Compare-and-subtract keeps the ones digit free of a divider.
  function automatic logic [3:0] ones_of(input logic [4:0] v);
    logic [4:0] r;
    r = v;
    if (r >= 5'd30)      r = r - 5'd30;
    else if (r >= 5'd20) r = r - 5'd20;
    else if (r >= 5'd10) r = r - 5'd10;
    return 4'(r);
  endfunction

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  assign slot_wrap = (slot_cnt == SLOT_LAST);
  assign boundary  = slot_wrap && (idx == 2'd3);
  assign nxt_slot  = slot_wrap ? 16'd0 : slot_cnt + 16'd1;
  assign nxt_idx   = slot_wrap ? idx + 2'd1 : idx;

  // A load landing on the boundary edge bypasses the pending buffer.
  assign nxt_shd1 = boundary ? (bus.load ? bus.count1 : pend1) : shd1;
  assign nxt_shd2 = boundary ? (bus.load ? bus.count2 : pend2) : shd2;

  // Outputs are decoded from next-state so they align with the counters.
  assign cur_val = nxt_idx[1] ? nxt_shd2 : nxt_shd1;
  assign is_tens = nxt_idx[0];
  assign tens_v  = tens_of(cur_val);
  assign ones_v  = ones_of(cur_val);
  assign digit   = is_tens ? {2'b00, tens_v} : ones_v;

`ifdef LZ_BLANK_EN
  assign lz_dark = is_tens && (tens_v == 2'd0);
`else
  assign lz_dark = 1'b0;
`endif

  assign lit   = (nxt_slot != 16'd0) && !bus.blank && !lz_dark;
  assign seg_d = lit ? seg_pat(digit) : 7'h00;
  assign an_d  = lit ? (4'b0001 << nxt_idx) : 4'b0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend1    <= 5'd0;
      pend2    <= 5'd0;
      shd1     <= 5'd0;
      shd2     <= 5'd0;
      slot_cnt <= 16'd0;
      idx      <= 2'd0;
      seg_q    <= 7'h00;
      an_q     <= 4'h0;
      frame_q  <= 1'b0;
    end else begin
      if (bus.load) begin
        pend1 <= bus.count1;
        pend2 <= bus.count2;
      end
      shd1     <= nxt_shd1;
      shd2     <= nxt_shd2;
      slot_cnt <= nxt_slot;
      idx      <= nxt_idx;
      seg_q    <= seg_d;
      an_q     <= an_d;
      frame_q  <= boundary;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.an    = an_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_countdown_seg_scanner.sv
// Checks countdown_seg_scanner (SCAN_DIV=4) against a frame-position model:
// directed scenarios followed by randomized loads and blanking.
module tb_countdown_seg_scanner;

  localparam int SD    = 4;
  localparam int FRAME = 4 * SD;

  logic clk;
  logic reset;
  countdown_seg_scanner_if bus ();

  countdown_seg_scanner #(.SCAN_DIV(SD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Model: position inside the frame counted in clock edges since reset.
  int pos;
  int m_pend1, m_pend2, m_shd1, m_shd2;
  bit m_blank_q;
  bit m_frame;
  logic [6:0] pat [10];

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s pos=%0d observed=%h expected=%h", tag, pos, obs, exp);
    end
  endtask

  task automatic model_reset();
    pos = 0; m_pend1 = 0; m_pend2 = 0; m_shd1 = 0; m_shd2 = 0;
    m_blank_q = 0; m_frame = 0;
  endtask

  task automatic model_edge();
    if (reset) return;
    if (bus.load) begin
      m_pend1 = int'(bus.count1);
      m_pend2 = int'(bus.count2);
    end
    pos = (pos + 1) % FRAME;
    m_frame = (pos == 0);
    if (pos == 0) begin
      m_shd1 = m_pend1;
      m_shd2 = m_pend2;
    end
    m_blank_q = bus.blank;
  endtask

  task automatic check_outputs();
    int slot, ins, v, dig;
    bit tens_slot, lit;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    slot = pos / SD;
    ins  = pos % SD;
    v = (slot < 2) ? m_shd1 : m_shd2;
    tens_slot = (slot % 2) == 1;
    dig = tens_slot ? v / 10 : v % 10;
    lit = (ins != 0) && !m_blank_q;
`ifdef LZ_BLANK_EN
    if (tens_slot && (v / 10) == 0) lit = 0;
`endif
    e_seg = lit ? pat[dig] : 7'h00;
    e_an  = lit ? 4'(1 << slot) : 4'h0;
    if (reset) begin
      e_seg = 7'h00; e_an = 4'h0;
    end
    chk("seg", bus.seg, e_seg);
    chk("an", {3'b000, bus.an}, {3'b000, e_an});
    chk("frame", {6'd0, bus.frame}, {6'd0, m_frame && !reset});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic advance_to(input int target);
    int budget;
    budget = 0;
    while (pos != target && budget < 4 * FRAME) begin
      step();
      budget++;
    end
    vectors++;
    assert (pos == target) else begin
      miscompares++;
      $error("FAIL advance_to observed=%0d expected=%0d", pos, target);
    end
  endtask

  task automatic do_load(input int c1, input int c2);
    bus.load = 1'b1;
    bus.count1 = 5'(c1);
    bus.count2 = 5'(c2);
    step();
    bus.load = 1'b0;
  endtask

  initial begin
    pat[0] = 7'h3F; pat[1] = 7'h06; pat[2] = 7'h5B; pat[3] = 7'h4F; pat[4] = 7'h66;
    pat[5] = 7'h6D; pat[6] = 7'h7D; pat[7] = 7'h07; pat[8] = 7'h7F; pat[9] = 7'h6F;
    vectors = 0;
    miscompares = 0;
    bus.load = 1'b0;
    bus.count1 = 5'd0;
    bus.count2 = 5'd0;
    bus.blank = 1'b0;
    model_reset();

    reset = 1'b1;
    #12;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;

    // Idle: two frames of 00/00.
    run(2 * FRAME);

    // Mid-frame load of 10/7 appears only from the next boundary.
    advance_to(5);
    do_load(10, 7);
    run(2 * FRAME);

    // Load exactly on the boundary edge is taken the same frame.
    advance_to(FRAME - 1);
    do_load(31, 20);
    run(FRAME);

    // Two loads in one frame: last wins.
    advance_to(3);
    do_load(5, 5);
    advance_to(8);
    do_load(9, 3);
    run(2 * FRAME);

    // Blanking for 20 cycles, then resume.
    bus.blank = 1'b1;
    run(20);
    bus.blank = 1'b0;
    run(FRAME + 4);

    // Asynchronous reset at slot 2, cycle 2 discards pending values.
    do_load(17, 28);
    advance_to(2 * SD + 2);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    run(2);
    @(negedge clk);
    reset = 1'b0;
    run(2 * FRAME);

    // Randomized loads and blanking.
    for (int i = 0; i < 500; i++) begin
      bus.load = ($urandom_range(0, 7) == 0);
      bus.count1 = 5'($urandom_range(0, 31));
      bus.count2 = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) bus.blank = ~bus.blank;
      step();
    end
    bus.load = 1'b0;
    bus.blank = 1'b0;
    run(FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
